// File: rtl/mesh_wormhole_pkg.sv
// ============================================================================
// mesh_wormhole_pkg : flit id encodings, port indices and round-robin helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package mesh_wormhole_pkg;

   typedef enum logic [1:0] {
      ID_BODY      = 2'b00,
      ID_TAIL      = 2'b01,
      ID_HEAD      = 2'b10,
      ID_HEAD_TAIL = 2'b11
   } flit_id_e;

   localparam int PORT_LOCAL = 0;
   localparam int PORT_NORTH = 1;
   localparam int PORT_EAST  = 2;
   localparam int PORT_SOUTH = 3;
   localparam int PORT_WEST  = 4;

   // Arbiter request vectors are sized for up to RR_MAX inputs.
   localparam int RR_MAX   = 16;
   localparam int RR_IDX_W = 4;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_sel_t;

   function automatic logic is_head(input logic [1:0] id);
      return (id == ID_HEAD) || (id == ID_HEAD_TAIL);
   endfunction

   function automatic logic is_tail(input logic [1:0] id);
      return (id == ID_TAIL) || (id == ID_HEAD_TAIL);
   endfunction

   // First requester found scanning upward from 'start', wrapping at n.
   function automatic rr_sel_t rr_pick(input logic [RR_MAX-1:0]   req,
                                       input logic [RR_IDX_W-1:0] start,
                                       input logic [RR_IDX_W:0]   n);
      rr_sel_t             sel;
      logic [RR_IDX_W:0]   k;
      sel = '0;
      for (int j = 0; j < RR_MAX; j++) begin
         k = {1'b0, start} + j[RR_IDX_W:0];
         if (k >= n) k = k - n;
         if (!sel.found && (j[RR_IDX_W:0] < n) && req[k[RR_IDX_W-1:0]]) begin
            sel.found = 1'b1;
            sel.idx   = k[RR_IDX_W-1:0];
         end
      end
      return sel;
   endfunction

endpackage

`default_nettype wire

// File: rtl/node_input_fifo.sv
// ============================================================================
// node_input_fifo : first-word-fall-through input buffer, 2**DEPTH_W entries
// Revision: 1.0
// ============================================================================
`default_nettype none

module node_input_fifo #(
   parameter int DEPTH_W = 2,
   parameter int DATA_W  = 10
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_vld_i,
   output logic              wr_rdy_o,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              rd_vld_o,
   input  logic              rd_pop_i,
   output logic [DATA_W-1:0] rd_data_o
);

   localparam int               DEPTH    = 1 << DEPTH_W;
   localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W+1)'(DEPTH);

   logic [DATA_W-1:0]  mem_q [DEPTH];
   logic [DATA_W-1:0]  mem_d [DEPTH];
   logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_W:0]   cnt_q, cnt_d;
   logic               push, pop;

   assign wr_rdy_o  = (cnt_q != FULL_CNT);
   assign rd_vld_o  = (cnt_q != '0);
   assign rd_data_o = mem_q[rd_ptr_q];
   assign push      = wr_vld_i && wr_rdy_o;
   assign pop       = rd_pop_i && rd_vld_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mesh_wormhole_node.sv
// ============================================================================
// mesh_wormhole_node : XY-routed wormhole mesh router with round-robin outputs
// Optional macro MESH_WORMHOLE_NODE_HOP_CNT_EN: increment head-flit hop count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mesh_wormhole_node
   import mesh_wormhole_pkg::*;
#(
   parameter int IN_N           = 5,
   parameter int OUT_M          = 5,
   parameter int FLIT_DATA_W    = 8,
   parameter int FLIT_ID_W      = 2,
   parameter int HOP_CNT_W      = 4,
   parameter int ROW_ADDR_W     = 2,
   parameter int COL_ADDR_W     = 2,
   parameter int ROW_CORD       = 0,
   parameter int COL_CORD       = 0,
   parameter int BUFFER_DEPTH_W = 2
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic [IN_N*(FLIT_ID_W+FLIT_DATA_W)-1:0]  in_chan_data_i,
   input  logic [IN_N-1:0]                          in_chan_vld_i,
   output logic [IN_N-1:0]                          in_chan_rdy_o,
   output logic [OUT_M*(FLIT_ID_W+FLIT_DATA_W)-1:0] out_chan_data_o,
   output logic [OUT_M-1:0]                         out_chan_vld_o,
   input  logic [OUT_M-1:0]                         out_chan_rdy_i
);

   localparam int FLIT_W    = FLIT_ID_W + FLIT_DATA_W;
   localparam int IN_IDX_W  = (IN_N  > 1) ? $clog2(IN_N)  : 1;
   localparam int OUT_IDX_W = (OUT_M > 1) ? $clog2(OUT_M) : 1;
   localparam int HOP_LSB   = ROW_ADDR_W + COL_ADDR_W;

   localparam logic [COL_ADDR_W-1:0] MY_COL = COL_ADDR_W'(COL_CORD);
   localparam logic [ROW_ADDR_W-1:0] MY_ROW = ROW_ADDR_W'(ROW_CORD);
   localparam logic [RR_IDX_W:0]     N_IN   = (RR_IDX_W+1)'(IN_N);

`ifdef MESH_WORMHOLE_NODE_HOP_CNT_EN
   localparam bit HOP_EN = 1'b1;
`else
   localparam bit HOP_EN = 1'b0;
`endif

   logic [FLIT_W-1:0]    fifo_data [IN_N];
   logic [IN_N-1:0]      fifo_vld;
   logic [IN_N-1:0]      fifo_pop;
   logic [OUT_IDX_W-1:0] route [IN_N];
   logic [IN_N-1:0]      in_locked;
   logic [IN_N-1:0]      head_req;
   logic [IN_N-1:0]      drop;

   logic [RR_MAX-1:0]    req_vec [OUT_M];
   rr_sel_t              sel [OUT_M];
   logic [OUT_M-1:0]     gnt_vld;
   logic [OUT_M-1:0]     active;
   logic [OUT_M-1:0]     xfer;
   logic [IN_IDX_W-1:0]  src [OUT_M];
   logic [FLIT_W-1:0]    out_flit [OUT_M];

   logic [OUT_M-1:0]     lock_vld_q, lock_vld_d;
   logic [IN_IDX_W-1:0]  lock_src_q [OUT_M];
   logic [IN_IDX_W-1:0]  lock_src_d [OUT_M];
   logic [RR_IDX_W-1:0]  rr_ptr_q [OUT_M];
   logic [RR_IDX_W-1:0]  rr_ptr_d [OUT_M];

   for (genvar gi = 0; gi < IN_N; gi++) begin : g_in_fifo
      node_input_fifo #(
         .DEPTH_W (BUFFER_DEPTH_W),
         .DATA_W  (FLIT_W)
      ) u_fifo (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .wr_vld_i  (in_chan_vld_i[gi]),
         .wr_rdy_o  (in_chan_rdy_o[gi]),
         .wr_data_i (in_chan_data_i[gi*FLIT_W +: FLIT_W]),
         .rd_vld_o  (fifo_vld[gi]),
         .rd_pop_i  (fifo_pop[gi]),
         .rd_data_o (fifo_data[gi])
      );
   end

   // XY routing of whatever flit sits at each FIFO head; used only for heads.
   always_comb begin
      for (int i = 0; i < IN_N; i++) begin
         if (fifo_data[i][COL_ADDR_W-1:0] > MY_COL)
            route[i] = OUT_IDX_W'(PORT_EAST);
         else if (fifo_data[i][COL_ADDR_W-1:0] < MY_COL)
            route[i] = OUT_IDX_W'(PORT_WEST);
         else if (fifo_data[i][COL_ADDR_W +: ROW_ADDR_W] > MY_ROW)
            route[i] = OUT_IDX_W'(PORT_SOUTH);
         else if (fifo_data[i][COL_ADDR_W +: ROW_ADDR_W] < MY_ROW)
            route[i] = OUT_IDX_W'(PORT_NORTH);
         else
            route[i] = OUT_IDX_W'(PORT_LOCAL);
      end
   end

   always_comb begin
      in_locked = '0;
      for (int o = 0; o < OUT_M; o++) begin
         if (lock_vld_q[o]) in_locked[lock_src_q[o]] = 1'b1;
      end
      for (int i = 0; i < IN_N; i++) begin
         head_req[i] = fifo_vld[i] && is_head(fifo_data[i][FLIT_W-1 -: 2]) && !in_locked[i];
         drop[i]     = fifo_vld[i] && !is_head(fifo_data[i][FLIT_W-1 -: 2]) && !in_locked[i];
      end
   end

   always_comb begin
      for (int o = 0; o < OUT_M; o++) begin
         req_vec[o] = '0;
         for (int i = 0; i < IN_N; i++) begin
            req_vec[o][i] = head_req[i] && (route[i] == OUT_IDX_W'(o));
         end
         sel[o]        = rr_pick(req_vec[o], rr_ptr_q[o], N_IN);
         gnt_vld[o]    = !lock_vld_q[o] && sel[o].found;
         active[o]     = lock_vld_q[o] || gnt_vld[o];
         src[o]        = lock_vld_q[o] ? lock_src_q[o] : sel[o].idx[IN_IDX_W-1:0];
         out_chan_vld_o[o] = active[o] && fifo_vld[src[o]];
         xfer[o]       = out_chan_vld_o[o] && out_chan_rdy_i[o];

         out_flit[o] = fifo_data[src[o]];
         if (HOP_EN && is_head(out_flit[o][FLIT_W-1 -: 2]) &&
             (out_flit[o][HOP_LSB +: HOP_CNT_W] != '1))
            out_flit[o][HOP_LSB +: HOP_CNT_W] = out_flit[o][HOP_LSB +: HOP_CNT_W] + 1'b1;
         out_chan_data_o[o*FLIT_W +: FLIT_W] = out_flit[o];

         // A lock lives from grant until its tail flit actually leaves.
         lock_vld_d[o] = active[o] && !(xfer[o] && is_tail(fifo_data[src[o]][FLIT_W-1 -: 2]));
         lock_src_d[o] = src[o];
         if (gnt_vld[o])
            rr_ptr_d[o] = (sel[o].idx == RR_IDX_W'(IN_N-1)) ? '0 : sel[o].idx + 1'b1;
         else
            rr_ptr_d[o] = rr_ptr_q[o];
      end
   end

   always_comb begin
      fifo_pop = drop;
      for (int o = 0; o < OUT_M; o++) begin
         if (xfer[o]) fifo_pop[src[o]] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_vld_q <= '0;
         for (int o = 0; o < OUT_M; o++) begin
            lock_src_q[o] <= '0;
            rr_ptr_q[o]   <= '0;
         end
      end else begin
         lock_vld_q <= lock_vld_d;
         for (int o = 0; o < OUT_M; o++) begin
            lock_src_q[o] <= lock_src_d[o];
            rr_ptr_q[o]   <= rr_ptr_d[o];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mesh_wormhole_node.sv
// ============================================================================
// tb_mesh_wormhole_node : directed checks of a node at row 1, col 1
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mesh_wormhole_node;

`ifdef MESH_WORMHOLE_NODE_HOP_CNT_EN
   localparam logic [7:0] HI = 8'h10;
`else
   localparam logic [7:0] HI = 8'h00;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [49:0] in_data;
   logic [4:0]  in_vld, in_rdy;
   logic [49:0] out_data;
   logic [4:0]  out_vld, out_rdy;

   int errors = 0;
   int checks = 0;

   logic [9:0] got [5][$];
   logic [9:0] exp4 [6];

   always #5 clk = ~clk;

   mesh_wormhole_node #(.ROW_CORD(1), .COL_CORD(1)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .in_chan_data_i  (in_data),
      .in_chan_vld_i   (in_vld),
      .in_chan_rdy_o   (in_rdy),
      .out_chan_data_o (out_data),
      .out_chan_vld_o  (out_vld),
      .out_chan_rdy_i  (out_rdy)
   );

   // Nothing changes between negedge and the next posedge, so this sees
   // exactly the flits taken at that posedge.
   always @(negedge clk) begin
      for (int p = 0; p < 5; p++)
         if (rst_n && out_vld[p] && out_rdy[p]) got[p].push_back(out_data[p*10 +: 10]);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      for (int p = 0; p < 5; p++) got[p].delete();
   endtask

   task automatic send(input int p, input logic [9:0] f);
      int n = 0;
      bit done = 1'b0;
      in_vld[p] = 1'b1;
      in_data[p*10 +: 10] = f;
      while (!done && n < 50) begin
         @(negedge clk);
         done = in_rdy[p];
         @(posedge clk);
         #1;
         n++;
      end
      in_vld[p] = 1'b0;
      check("send_accept", 32'(done), 32'd1);
   endtask

   initial begin
      rst_n   = 1'b0;
      in_vld  = '0;
      in_data = '0;
      out_rdy = '1;
      cycles(2);
      @(negedge clk);
      check("reset_out_vld", 32'(out_vld), 32'h0);
      check("reset_in_rdy", 32'(in_rdy), 32'h1f);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycles(1);

      // Single-flit packet to Local.
      send(2, {2'b11, 8'h05});
      @(negedge clk);
      check("ht_local_vld", 32'(out_vld), 32'h01);
      check("ht_local_data", 32'(out_data[9:0]), 32'({2'b11, 8'h05 + HI}));
      cycles(2);
      check("ht_local_idle", 32'(out_vld), 32'h0);
      check("ht_local_count", got[0].size(), 1);
      clear_q();

      // Three-flit packet to East.
      send(0, {2'b10, 8'h06});
      send(0, {2'b00, 8'hAA});
      send(0, {2'b01, 8'hBB});
      cycles(4);
      check("east_count", got[2].size(), 3);
      check("east_head", 32'(got[2][0]), 32'({2'b10, 8'h06 + HI}));
      check("east_body", 32'(got[2][1]), 32'({2'b00, 8'hAA}));
      check("east_tail", 32'(got[2][2]), 32'({2'b01, 8'hBB}));
      check("east_idle", 32'(out_vld), 32'h0);

      rst_n = 1'b0;
      cycles(1);
      rst_n = 1'b1;
      cycles(1);
      clear_q();

      // Two inputs contend for East in the same cycle; no interleaving.
      in_vld = 5'b00011;
      in_data[9:0]   = {2'b10, 8'h06};
      in_data[19:10] = {2'b10, 8'h06};
      cycles(1);
      in_data[9:0]   = {2'b01, 8'h11};
      in_data[19:10] = {2'b01, 8'h22};
      cycles(1);
      in_vld = '0;
      cycles(6);
      check("arb_count", got[2].size(), 4);
      check("arb_p0_head", 32'(got[2][0]), 32'({2'b10, 8'h06 + HI}));
      check("arb_p0_tail", 32'(got[2][1]), 32'({2'b01, 8'h11}));
      check("arb_p1_head", 32'(got[2][2]), 32'({2'b10, 8'h06 + HI}));
      check("arb_p1_tail", 32'(got[2][3]), 32'({2'b01, 8'h22}));
      clear_q();

      // South output stalled: source buffer fills after four flits.
      out_rdy[3] = 1'b0;
      exp4[0] = {2'b10, 8'h09 + HI};
      exp4[1] = {2'b00, 8'h31};
      exp4[2] = {2'b00, 8'h32};
      exp4[3] = {2'b00, 8'h33};
      exp4[4] = {2'b00, 8'h34};
      exp4[5] = {2'b01, 8'h35};
      send(0, {2'b10, 8'h09});
      send(0, {2'b00, 8'h31});
      send(0, {2'b00, 8'h32});
      send(0, {2'b00, 8'h33});
      in_vld[0] = 1'b1;
      in_data[9:0] = {2'b00, 8'h34};
      @(negedge clk);
      check("stall_rdy_low", 32'(in_rdy[0]), 32'd0);
      check("stall_vld", 32'(out_vld[3]), 32'd1);
      check("stall_data", 32'(out_data[39:30]), 32'(exp4[0]));
      repeat (3) @(negedge clk);
      check("stall_rdy_still_low", 32'(in_rdy[0]), 32'd0);
      check("stall_data_stable", 32'(out_data[39:30]), 32'(exp4[0]));
      @(posedge clk); #1;
      out_rdy[3] = 1'b1;
      send(0, {2'b00, 8'h34});
      send(0, {2'b01, 8'h35});
      cycles(8);
      check("stall_count", got[3].size(), 6);
      for (int k = 0; k < 6; k++) check("stall_flit", 32'(got[3][k]), 32'(exp4[k]));
      clear_q();

      // Reset in the middle of a packet.
      out_rdy[2] = 1'b0;
      send(0, {2'b10, 8'h06});
      send(0, {2'b00, 8'h44});
      cycles(1);
      rst_n = 1'b0;
      #2;
      check("midrst_vld", 32'(out_vld), 32'h0);
      check("midrst_rdy", 32'(in_rdy), 32'h1f);
      @(posedge clk); #1;
      rst_n   = 1'b1;
      out_rdy = '1;
      cycles(1);
      send(0, {2'b00, 8'h77});
      @(negedge clk);
      check("orphan_vld", 32'(out_vld), 32'h0);
      cycles(3);
      check("orphan_dropped",
            got[0].size() + got[1].size() + got[2].size() + got[3].size() + got[4].size(), 0);
      send(4, {2'b11, 8'h01});
      @(negedge clk);
      check("north_vld", 32'(out_vld), 32'h02);
      check("north_data", 32'(out_data[19:10]), 32'({2'b11, 8'h01 + HI}));
      cycles(3);
      check("north_count", got[1].size(), 1);
      clear_q();

      // Single-flit packet to West.
      send(2, {2'b11, 8'h04});
      @(negedge clk);
      check("west_vld", 32'(out_vld), 32'h10);
      check("west_data", 32'(out_data[49:40]), 32'({2'b11, 8'h04 + HI}));
      cycles(3);
      check("west_count", got[4].size(), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
